uart_rx_tx: RTL and testbench



---
 rtl/uart_rx_tx_pkg.sv | 24 ++
 rtl/uart_rx_tx_rx_path.sv | 105 ++++++++++
 rtl/uart_rx_tx_tx_path.sv | 77 +++++++
 rtl/uart_rx_tx.sv | 39 +++
 tb/tb_uart_rx_tx.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_tx_pkg.sv
// Shared types and constants for the 8N1 UART transmit and receive paths.
package uart_rx_tx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 521;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_CLEANUP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_tx_rx_path.sv
// 8N1 deserialiser: synchronises the line, qualifies the start bit at mid-bit, samples data mid-bit.
module uart_rx_path
  import uart_rx_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial,
  output logic [7:0] data,
  output logic       valid
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);

  rx_state_t     state;
  rx_state_t     state_nxt;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          half_hit;
  logic          bit_end;
  logic          cnt_clr;
  logic          sample_bit;
  logic          load_out;

  // Synchroniser resets to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], serial};
    end
  end

  assign rx_s     = sync[1];
  assign half_hit = (cnt == HALF_CNT);
  assign bit_end  = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RX_IDLE:    if (rx_s == START_BIT) state_nxt = RX_START;
      RX_START:   if (half_hit) state_nxt = (rx_s == START_BIT) ? RX_DATA : RX_IDLE;
      RX_DATA:    if (bit_end && idx == 3'd7) state_nxt = RX_STOP;
      RX_STOP:    if (bit_end) state_nxt = RX_CLEANUP;
      RX_CLEANUP: state_nxt = RX_IDLE;
      default:    state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr    = 1'b1;
    sample_bit = 1'b0;
    load_out   = 1'b0;
    unique case (state)
      RX_START: cnt_clr = half_hit;
      RX_DATA: begin
        cnt_clr    = bit_end;
        sample_bit = bit_end;
      end
      RX_STOP: begin
        cnt_clr  = bit_end;
        load_out = bit_end && (rx_s == STOP_BIT);
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // A framing error simply never asserts load_out, leaving data untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      cnt   <= cnt_clr ? '0 : cnt + 1'b1;
      valid <= load_out;
      if (state == RX_IDLE) begin
        idx <= '0;
      end else if (sample_bit) begin
        shift[idx] <= rx_s;
        idx        <= idx + 3'd1;
      end
      if (load_out) begin
        data <= shift;
      end
    end
  end

endmodule

// File: rtl/uart_rx_tx_tx_path.sv
// Free-running 8N1 serialiser: one IDLE cycle latches the byte, then start, 8 data bits LSB first, stop.
module uart_tx_path
  import uart_rx_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  output logic       serial,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  tx_state_t     state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          bit_end;

  assign bit_end = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= TX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      TX_IDLE:  state_nxt = TX_START;
      TX_START: if (bit_end) state_nxt = TX_DATA;
      TX_DATA:  if (bit_end && idx == 3'd7) state_nxt = TX_STOP;
      TX_STOP:  if (bit_end) state_nxt = TX_IDLE;
      default:  state_nxt = TX_IDLE;
    endcase
  end

  // The bit index wraps from 7 back to 0 on leaving DATA, so no explicit clear is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      if (state == TX_IDLE) begin
        shift <= data;
      end
      if (state == TX_IDLE || bit_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (state == TX_DATA && bit_end) begin
        idx <= idx + 3'd1;
      end
    end
  end

  always_comb begin
    serial = STOP_BIT;
    done   = 1'b0;
    unique case (state)
      TX_START: serial = START_BIT;
      TX_DATA:  serial = shift[idx];
      TX_STOP:  done   = bit_end;
      default:  serial = STOP_BIT;
    endcase
  end

endmodule

// File: rtl/uart_rx_tx.sv
// 8N1 UART with independent free-running transmitter and receiver; CLKS_PER_BIT must be at least 4.
module uart_rx_tx
  import uart_rx_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_in,
  output logic       tx_out,
  output logic       tx_done,
  input  logic       rx_in,
  output logic [7:0] rx_out,
  output logic       rx_valid
);

  uart_tx_path #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (i_clk),
    .rst_n (rst_n),
    .data  (tx_in),
    .serial(tx_out),
    .done  (tx_done)
  );

  // rx_valid is a one-cycle strobe with no back-pressure: rx_out is updated in the same
  // cycle and then holds until the next good frame, so a consumer may sample it any time.
  uart_rx_path #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk   (i_clk),
    .rst_n (rst_n),
    .serial(rx_in),
    .data  (rx_out),
    .valid (rx_valid)
  );

endmodule

// File: tb/tb_uart_rx_tx.sv
// Directed bench for uart_rx_tx: RX framing cases, TX loopback timing and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx_tx;
  import uart_rx_tx_pkg::*;

  localparam int BIT_NS = 10416;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_in = 8'hA5;
  logic       tx_out;
  logic       tx_done;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_line;
  logic [7:0] rx_out;
  logic       rx_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int d1, d2, dcount;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #10 clk = ~clk;

  assign rx_line = loop_en ? tx_out : rx_drv;

  uart_rx_tx dut (
    .i_clk   (clk),
    .rst_n   (rst_n),
    .tx_in   (tx_in),
    .tx_out  (tx_out),
    .tx_done (tx_done),
    .rx_in   (rx_line),
    .rx_out  (rx_out),
    .rx_valid(rx_valid)
  );

  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_out);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input int start_ns);
    rx_drv = 1'b0;
    #(start_ns);
    for (int i = 0; i < nbits; i++) begin
      rx_drv = b[i];
      #(BIT_NS);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stretch_ns, input logic stop_ok);
    send_bits(b, 8, BIT_NS + stretch_ns);
    if (stop_ok) begin
      rx_drv = 1'b1;
      #(BIT_NS);
    end else begin
      rx_drv = 1'b0;
      #(BIT_NS * 3 / 4);
      rx_drv = 1'b1;
      #(BIT_NS / 4);
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_tx_out", 32'(tx_out), 32'd1);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_rx_out", 32'(rx_out), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    rst_n = 1'b1;

    // stretched start bit
    #(BIT_NS);
    send_byte(8'hE3, 1000, 1'b1);
    #(BIT_NS);
    exp_q.push_back(8'hE3);
    check_rx("e3");
    check("e3_hold", 32'(rx_out), 32'hE3);

    // back-to-back frames
    send_byte(8'h00, 0, 1'b1);
    send_byte(8'hFF, 0, 1'b1);
    send_byte(8'h55, 0, 1'b1);
    #(BIT_NS);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    check_rx("b2b");

    // short low glitch
    rx_drv = 1'b0;
    repeat (100) @(negedge clk);
    rx_drv = 1'b1;
    repeat (600) @(negedge clk);
    check_rx("glitch");
    check("glitch_hold", 32'(rx_out), 32'h55);
    check("glitch_idle", 32'(dut.u_rx.state), 32'(RX_IDLE));

    // framing error then a good frame
    send_byte(8'h3C, 0, 1'b0);
    #(BIT_NS);
    check_rx("ferr");
    check("ferr_hold", 32'(rx_out), 32'h55);
    send_byte(8'h81, 0, 1'b1);
    #(BIT_NS);
    exp_q.push_back(8'h81);
    check_rx("ferr_next");
    check("ferr_next_out", 32'(rx_out), 32'h81);

    // loopback from a fresh reset
    @(negedge clk);
    rst_n   = 1'b0;
    loop_en = 1'b1;
    repeat (3) @(negedge clk);
    check("lb_reset_tx", 32'(tx_out), 32'd1);
    got_q.delete();
    rst_n  = 1'b1;
    dcount = 0;
    d1     = -1;
    d2     = -1;
    for (int k = 1; k <= 10440; k++) begin
      @(negedge clk);
      if (k == 1)    check("lb_start0", 32'(tx_out), 32'd0);
      if (k == 5211) check("lb_idle_gap", 32'(tx_out), 32'd1);
      if (k == 5212) check("lb_start1", 32'(tx_out), 32'd0);
      if (tx_done) begin
        dcount++;
        if (dcount == 1) d1 = k;
        else if (dcount == 2) d2 = k;
      end
    end
    check("lb_done_cnt", 32'(dcount), 32'd2);
    check("lb_done_first", 32'(d1), 32'd5210);
    check("lb_period", 32'(d2 - d1), 32'd5211);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    check_rx("lb");
    check("lb_rx_out", 32'(rx_out), 32'hA5);

    // reset in the middle of an RX frame (TX is always mid-frame)
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (600) @(negedge clk);
    got_q.delete();
    send_bits(8'h33, 4, BIT_NS);
    @(negedge clk);
    rst_n  = 1'b0;
    rx_drv = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_out", 32'(tx_out), 32'd1);
    check("mid_rst_rx_out", 32'(rx_out), 32'h00);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_rx_idle", 32'(dut.u_rx.state), 32'(RX_IDLE));
    check("mid_rst_tx_idle", 32'(dut.u_tx.state), 32'(TX_IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check_rx("mid_rst_abort");
    send_byte(8'h5A, 0, 1'b1);
    #(BIT_NS);
    exp_q.push_back(8'h5A);
    check_rx("mid_rst_fresh");
    check("mid_rst_fresh_out", 32'(rx_out), 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
